// File: rtl/text_row_scheduler.sv
// Turns one OLED pixel-byte request into a char lookup, font ROM read and registered pixel byte.
// Latency: pixelValid 5 cycles after accept for text/bin/hex rows, 4 for progress rows; single request in flight.
module text_row_scheduler #(
  parameter int         FONT_BASE_CHAR  = 32,
  parameter int         FONT_LAST_CHAR  = 127,
  parameter int         FONT_ADDR_WIDTH = 11,
  parameter logic [7:0] DEFAULT_TYPES   = 8'b11100100
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pixelReq,
  input  logic [9:0]                 pixelAddress,
  output logic                       reqReady,
  output logic [7:0]                 pixelData,
  output logic                       pixelValid,
  output logic [3:0]                 outputCharIndex,
  output logic [9:0]                 rowPixelAddress,
  output logic [1:0]                 rowSelect,
  input  logic [7:0]                 textByte,
  input  logic [7:0]                 binByte,
  input  logic [7:0]                 hexByte,
  input  logic [7:0]                 progressByte,
  output logic [FONT_ADDR_WIDTH-1:0] fontAddr,
  input  logic [7:0]                 fontData,
  input  logic                       cfgWe,
  input  logic [1:0]                 cfgRow,
  input  logic [1:0]                 cfgType
);

  localparam logic [1:0] TYPE_TEXT  = 2'd0;
  localparam logic [1:0] TYPE_BIN   = 2'd1;
  localparam logic [1:0] TYPE_HEX   = 2'd2;
  localparam logic [1:0] TYPE_PROG  = 2'd3;
  localparam logic [7:0] BASE_CHAR  = FONT_BASE_CHAR[7:0];
  localparam logic [7:0] LAST_CHAR  = FONT_LAST_CHAR[7:0];
  localparam logic [7:0] SPACE_CHAR = 8'd32;

  typedef enum logic [2:0] {IDLE, CHAR, CAPTURE, FONT, DONE} state_t;

  state_t                     state, nextState;
  logic [9:0]                 addrLatch;
  logic [1:0]                 rowType;
  logic [7:0]                 rowMap;
  logic [7:0]                 capByte;
  logic [7:0]                 srcByte;
  logic [7:0]                 charEff;
  logic [FONT_ADDR_WIDTH-1:0] glyphIdx;
  logic [FONT_ADDR_WIDTH-1:0] fontAddrNext;

  assign outputCharIndex = addrLatch[6:3];
  assign rowPixelAddress = addrLatch;
  assign rowSelect       = addrLatch[9:8];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    reqReady  = 1'b0;
    case (state)
      IDLE: begin
        reqReady = 1'b1;
        if (pixelReq) nextState = CHAR;
      end
      CHAR:    nextState = CAPTURE;
      CAPTURE: nextState = (rowType == TYPE_PROG) ? DONE : FONT;
      FONT:    nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    srcByte = textByte;
    case (rowType)
      TYPE_TEXT: srcByte = textByte;
      TYPE_BIN:  srcByte = binByte;
      TYPE_HEX:  srcByte = hexByte;
      TYPE_PROG: srcByte = progressByte;
      default:   srcByte = textByte;
    endcase
  end

  // Characters outside the ROM range render as a blank glyph; {page[0], col[2:0]} picks the byte within it.
  always_comb begin
    charEff      = (srcByte >= BASE_CHAR && srcByte <= LAST_CHAR) ? srcByte : SPACE_CHAR;
    glyphIdx     = FONT_ADDR_WIDTH'(charEff - BASE_CHAR);
    fontAddrNext = (glyphIdx << 4) + FONT_ADDR_WIDTH'({addrLatch[7], addrLatch[2:0]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addrLatch  <= '0;
      rowType    <= TYPE_TEXT;
      rowMap     <= DEFAULT_TYPES;
      capByte    <= '0;
      fontAddr   <= '0;
      pixelData  <= '0;
      pixelValid <= 1'b0;
    end else begin
      pixelValid <= 1'b0;
      if (cfgWe) rowMap[{cfgRow, 1'b0} +: 2] <= cfgType;
      case (state)
        IDLE: begin
          if (pixelReq) begin
            addrLatch <= pixelAddress;
            rowType   <= rowMap[{pixelAddress[9:8], 1'b0} +: 2];
          end
        end
        CAPTURE: begin
          capByte <= srcByte;
          // Registering the address here presents it to the ROM for the whole FONT cycle.
          if (rowType != TYPE_PROG) fontAddr <= fontAddrNext;
        end
        DONE: begin
          pixelData  <= (rowType == TYPE_PROG) ? capByte : fontData;
          pixelValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_row_scheduler.sv
// Bench for text_row_scheduler: registered row sources and font ROM around the DUT,
// a request-level reference model checked every cycle, plus hand-computed directed expectations.
module tb_text_row_scheduler;

  logic        clk = 1'b0;
  logic        rst, pixelReq, cfgWe;
  logic [9:0]  pixelAddress;
  logic [1:0]  cfgRow, cfgType;
  logic        reqReady, pixelValid;
  logic [7:0]  pixelData;
  logic [3:0]  outputCharIndex;
  logic [9:0]  rowPixelAddress;
  logic [1:0]  rowSelect;
  logic [7:0]  textByte, binByte, hexByte, progressByte, fontData;
  logic [10:0] fontAddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  text_row_scheduler dut (
    .clk(clk), .rst(rst), .pixelReq(pixelReq), .pixelAddress(pixelAddress),
    .reqReady(reqReady), .pixelData(pixelData), .pixelValid(pixelValid),
    .outputCharIndex(outputCharIndex), .rowPixelAddress(rowPixelAddress),
    .rowSelect(rowSelect), .textByte(textByte), .binByte(binByte),
    .hexByte(hexByte), .progressByte(progressByte), .fontAddr(fontAddr),
    .fontData(fontData), .cfgWe(cfgWe), .cfgRow(cfgRow), .cfgType(cfgType)
  );

  // Environment: row sources and font ROM, each with one cycle of read latency.
  logic [7:0] textMem [16];
  logic [7:0] binMem  [16];
  logic [7:0] hexMem  [16];

  function automatic logic [7:0] romFn(input logic [10:0] a);
    if (a == 11'h210) return 8'h7C;
    return a[7:0] ^ {a[10:8], 5'b0} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] progFn(input logic [9:0] a);
    return a[7:0] ^ 8'hCF;
  endfunction

  always @(posedge clk) begin
    textByte     <= textMem[outputCharIndex];
    binByte      <= binMem[outputCharIndex];
    hexByte      <= hexMem[outputCharIndex];
    progressByte <= progFn(rowPixelAddress);
    fontData     <= romFn(fontAddr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per accepted request, work out the byte and timing from the row rules.
  logic [1:0]  mapM [4];
  int          cyc = 0;
  int          readyAt = 0, validAt = -1, faAt = -1;
  bit          pend = 0, chkEn = 0, expIsProg = 0;
  logic [7:0]  expData, curData;
  logic [10:0] expFa;

  function automatic logic [10:0] glyphAddr(input logic [7:0] c, input logic [9:0] a);
    int cc;
    cc = (c >= 32 && c <= 127) ? int'(c) : 32;
    return 11'((cc - 32) * 16 + (a[7] ? 8 : 0) + int'(a[2:0]));
  endfunction

  always @(posedge clk) begin
    logic [1:0] t;
    logic [7:0] c;
    if (rst) begin
      mapM[0] = 2'd0; mapM[1] = 2'd1; mapM[2] = 2'd2; mapM[3] = 2'd3;
      pend = 0; readyAt = 0; curData = 8'h00; chkEn = 1;
    end else begin
      if (pixelReq && cyc >= readyAt) begin
        t = mapM[pixelAddress[9:8]];
        pend = 1;
        faAt = cyc + 3;
        if (t == 2'd3) begin
          expIsProg = 1;
          expData   = progFn(pixelAddress);
          validAt   = cyc + 4;
        end else begin
          expIsProg = 0;
          c = (t == 2'd0) ? textMem[pixelAddress[6:3]] :
              (t == 2'd1) ? binMem[pixelAddress[6:3]] : hexMem[pixelAddress[6:3]];
          expFa   = glyphAddr(c, pixelAddress);
          expData = romFn(expFa);
          validAt = cyc + 5;
        end
        readyAt = validAt;
      end
      if (cfgWe) mapM[cfgRow] = cfgType;
    end
    cyc++;
    if (pend && cyc == validAt) curData = expData;
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("reqReady", {31'b0, reqReady}, {31'b0, cyc >= readyAt});
      chk("pixelValid", {31'b0, pixelValid}, {31'b0, pend && cyc == validAt});
      chk("pixelData", {24'b0, pixelData}, {24'b0, curData});
      if (pend && !expIsProg && cyc == faAt) chk("fontAddr", {21'b0, fontAddr}, {21'b0, expFa});
    end
  end

  // One request starting in the current cycle (k=0); side stimulus at chosen cycle offsets.
  task automatic doReq(input logic [9:0] a, input int cfgK, input logic [1:0] cR,
                       input logic [1:0] cT, input int extraK, input int rstK,
                       output int lat, output logic [10:0] fa3, output logic rdyAfterRst);
    int k;
    k = 0;
    lat = -1;
    fa3 = 11'h0;
    rdyAfterRst = 1'b0;
    pixelReq = 1'b1;
    pixelAddress = a;
    cfgRow = cR;
    cfgType = cT;
    while (k < 12) begin
      @(negedge clk);
      k++;
      pixelReq = (k == extraK);
      cfgWe    = (k == cfgK);
      rst      = (k == rstK);
      if (k == 3) fa3 = fontAddr;
      if (rstK >= 0 && k == rstK + 1) rdyAfterRst = reqReady;
      if (pixelValid) begin
        lat = k;
        break;
      end
    end
    pixelReq = 1'b0;
    cfgWe = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    logic [10:0] fa, faBefore;
    logic rdy;

    for (int i = 0; i < 16; i++) begin
      textMem[i] = 8'h41 + 8'(i);
      binMem[i]  = 8'h30 + 8'(i);
      hexMem[i]  = 8'h61 + 8'(i);
    end
    textMem[1] = 8'h07;
    textMem[2] = 8'hC8;
    textMem[3] = 8'h7F;

    rst = 1'b1; pixelReq = 1'b0; pixelAddress = '0; cfgWe = 1'b0; cfgRow = '0; cfgType = '0;
    repeat (3) @(negedge clk);
    chk("reset reqReady", {31'b0, reqReady}, 32'd1);
    chk("reset fontAddr", {21'b0, fontAddr}, 32'h0);
    chk("reset pixelData", {24'b0, pixelData}, 32'h0);
    chk("reset rowPixelAddress", {22'b0, rowPixelAddress}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    doReq(10'h000, -1, 2'd0, 2'd0, -1, -1, lat, fa, rdy);
    chk("t1 latency", lat, 32'd5);
    chk("t1 fontAddr", {21'b0, fa}, 32'h210);
    chk("t1 pixelData", {24'b0, pixelData}, 32'h7C);

    doReq(10'h085, -1, 2'd0, 2'd0, -1, -1, lat, fa, rdy);
    chk("t2 latency", lat, 32'd5);
    chk("t2 fontAddr", {21'b0, fa}, 32'h21D);
    chk("t2 pixelData", {24'b0, pixelData}, 32'h07);

    faBefore = fontAddr;
    doReq(10'h3C0, -1, 2'd0, 2'd0, -1, -1, lat, fa, rdy);
    chk("t3 latency", lat, 32'd4);
    chk("t3 pixelData", {24'b0, pixelData}, 32'h0F);
    chk("t3 fontAddr held", {21'b0, fontAddr}, {21'b0, faBefore});
    chk("t3 fontAddr value", {21'b0, fontAddr}, 32'h21D);

    doReq(10'h00B, -1, 2'd0, 2'd0, -1, -1, lat, fa, rdy);
    chk("t4 low char fontAddr", {21'b0, fa}, 32'h003);
    chk("t4 low char pixelData", {24'b0, pixelData}, 32'h59);
    doReq(10'h013, -1, 2'd0, 2'd0, -1, -1, lat, fa, rdy);
    chk("t4 high char fontAddr", {21'b0, fa}, 32'h003);
    doReq(10'h018, -1, 2'd0, 2'd0, -1, -1, lat, fa, rdy);
    chk("t4 last char fontAddr", {21'b0, fa}, 32'h5F0);
    chk("t4 last char pixelData", {24'b0, pixelData}, 32'h0A);

    doReq(10'h100, -1, 2'd0, 2'd0, -1, -1, lat, fa, rdy);
    chk("bin fontAddr", {21'b0, fa}, 32'h100);
    chk("bin pixelData", {24'b0, pixelData}, 32'h7A);
    doReq(10'h210, -1, 2'd0, 2'd0, -1, -1, lat, fa, rdy);
    chk("hex fontAddr", {21'b0, fa}, 32'h430);
    chk("hex pixelData", {24'b0, pixelData}, 32'hEA);

    doReq(10'h000, 1, 2'd0, 2'd2, 2, -1, lat, fa, rdy);
    chk("t5 inflight latency", lat, 32'd5);
    chk("t5 inflight fontAddr", {21'b0, fa}, 32'h210);
    chk("t5 inflight pixelData", {24'b0, pixelData}, 32'h7C);
    doReq(10'h000, -1, 2'd0, 2'd0, -1, -1, lat, fa, rdy);
    chk("t5 remapped fontAddr", {21'b0, fa}, 32'h410);
    chk("t5 remapped pixelData", {24'b0, pixelData}, 32'hCA);

    doReq(10'h000, -1, 2'd0, 2'd0, -1, 3, lat, fa, rdy);
    chk("t6 no pixelValid", lat, 32'hFFFFFFFF);
    chk("t6 reqReady after rst", {31'b0, rdy}, 32'd1);
    chk("t6 pixelData cleared", {24'b0, pixelData}, 32'h0);
    chk("t6 fontAddr cleared", {21'b0, fontAddr}, 32'h0);
    doReq(10'h000, -1, 2'd0, 2'd0, -1, -1, lat, fa, rdy);
    chk("t6 map restored fontAddr", {21'b0, fa}, 32'h210);
    chk("t6 map restored pixelData", {24'b0, pixelData}, 32'h7C);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
